maxpool2d: RTL and testbench



---
 rtl/maxpool2d.sv | 117 +++++++++++
 tb/tb_maxpool2d.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2d.sv
// Streaming 2x2 / stride-2 signed max-pooling stage.
// Consumes raster-ordered samples over valid/ready and emits one maximum per
// non-overlapping 2x2 window. A half-width line buffer carries the horizontal
// pair maxima of each even row until the matching odd row arrives.
module maxpool2d #(
  parameter int LineWidthPx = 158,
  parameter int LineCountPx = 118,
  parameter int Width       = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic signed [Width-1:0] data_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic signed [Width-1:0] data_o
);

  localparam int XW     = (LineWidthPx > 1) ? $clog2(LineWidthPx) : 1;
  localparam int YW     = (LineCountPx > 1) ? $clog2(LineCountPx) : 1;
  localparam int HalfW  = LineWidthPx / 2;
  localparam int RbAw   = (HalfW > 1) ? $clog2(HalfW) : 1;
  localparam int WEven  = HalfW * 2;
  localparam int HEven  = (LineCountPx / 2) * 2;

  typedef logic signed [Width-1:0] sample_t;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  sample_t       hold_q, hold_d;
  sample_t       data_q, data_d;
  logic          valid_q, valid_d;

  sample_t       rowbuf_q [HalfW];

  logic            in_fire;
  logic            x_last, y_last;
  logic            col_ok, row_ok;
  logic            odd_x, odd_y;
  logic            rb_we, produce;
  logic [RbAw-1:0] rb_idx;
  sample_t         rb_rd, pair_max, result;

  // The output stage can take a new result whenever it is empty or draining.
  assign ready_o = ~valid_q | ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Position tracking, horizontal/vertical max and the elastic output register.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    x_d      = x_q;
    y_d      = y_q;
    hold_d   = hold_q;
    valid_d  = valid_q;
    data_d   = data_q;

    in_fire  = valid_i & ready_o;
    x_last   = (x_q == XW'(LineWidthPx - 1));
    y_last   = (y_q == YW'(LineCountPx - 1));
    col_ok   = (int'(x_q) < WEven);
    row_ok   = (int'(y_q) < HEven);
    odd_x    = x_q[0];
    odd_y    = y_q[0];
    rb_idx   = RbAw'(x_q >> 1);
    rb_rd    = rowbuf_q[rb_idx];
    pair_max = (data_i > hold_q) ? data_i : hold_q;
    result   = (rb_rd > pair_max) ? rb_rd : pair_max;
    rb_we    = in_fire & odd_x & col_ok & ~odd_y & row_ok;
    produce  = in_fire & odd_x & col_ok &  odd_y & row_ok;

    if (in_fire) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
      if (~odd_x && col_ok) hold_d = data_i;
    end

    if (ready_o) begin
      valid_d = produce;
      if (produce) data_d = result;
    end
  end

  // Control and data flops; all reset asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      x_q     <= '0;
      y_q     <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // Line buffer of even-row pair maxima.
  always_ff @(posedge clk_i) begin
    // NOTE: the line buffer is deliberately not reset; each entry is written
    // in an even row before the odd row reads it, and leaving it reset-free
    // lets it map onto plain RAM.
    if (rb_we) rowbuf_q[rb_idx] <= pair_max;
  end

endmodule

// File: tb/tb_maxpool2d.sv
// Self-checking bench for maxpool2d: a 4x4 and a 5x5 instance share one
// stimulus driver; a frame-level reference model computes every window max
// from the whole frame and a negedge monitor compares accepted outputs.
module tb_maxpool2d;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              valid_i;
  logic              ready_i;
  logic signed [7:0] data_i;
  logic              sel;

  logic              v4, r4, v5, r5;
  logic signed [7:0] d4, d5;
  logic              vo, ro;
  logic signed [7:0] dout;

  always #5 clk_i = ~clk_i;

  maxpool2d #(.LineWidthPx(4), .LineCountPx(4), .Width(8)) u_dut4 (
    .clk_i(clk_i), .rst_i(rst_i),
    .valid_i(valid_i & ~sel), .ready_o(r4), .data_i(data_i),
    .valid_o(v4), .ready_i(ready_i), .data_o(d4)
  );

  maxpool2d #(.LineWidthPx(5), .LineCountPx(5), .Width(8)) u_dut5 (
    .clk_i(clk_i), .rst_i(rst_i),
    .valid_i(valid_i & sel), .ready_o(r5), .data_i(data_i),
    .valid_o(v5), .ready_i(ready_i), .data_o(d5)
  );

  assign vo   = sel ? v5 : v4;
  assign ro   = sel ? r5 : r4;
  assign dout = sel ? d5 : d4;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int sample_no = 0;
  bit lat_chk  = 0;
  bit pending  = 0;

  int exp_q[$];
  int exp_pix_q[$];
  int acc_cyc[int];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Output monitor: latency on first appearance, value on acceptance.
  always @(negedge clk_i) begin
    if (rst_i) begin
      pending = 0;
    end else begin
      if (vo && !pending && lat_chk && exp_pix_q.size() > 0 &&
          acc_cyc.exists(exp_pix_q[0]))
        check("latency", cyc, acc_cyc[exp_pix_q[0]] + 1);
      if (vo && ready_i) begin
        check("out_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          check("out_data", int'(dout), exp_q.pop_front());
          void'(exp_pix_q.pop_front());
        end
      end
      pending = vo & ~ready_i;
    end
  end

  // Reference: max of each 2x2 window of the whole frame, raster order.
  task automatic model_frame(input int w, input int h, input int start, input int fr[$]);
    for (int py = 0; py < h / 2; py++) begin
      for (int px = 0; px < w / 2; px++) begin
        int m;
        int a = fr[(2*py)*w + 2*px];
        int b = fr[(2*py)*w + 2*px + 1];
        int c = fr[(2*py+1)*w + 2*px];
        int d = fr[(2*py+1)*w + 2*px + 1];
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        exp_q.push_back(m);
        exp_pix_q.push_back(start + (2*py+1)*w + 2*px + 1);
      end
    end
  endtask

  // Present one sample and hold it until accepted; entered at posedge+1.
  task automatic send_one(input int v, input bit gaps);
    bit f = 0;
    int waited = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        valid_i = 1'b0;
        @(posedge clk_i); #1;
      end
    end
    valid_i = 1'b1;
    data_i  = v[7:0];
    while (!f && waited < 2000) begin
      @(negedge clk_i);
      f = ro;
      if (f) acc_cyc[sample_no] = cyc;
      @(posedge clk_i); #1;
      waited++;
    end
    valid_i = 1'b0;
    if (f) sample_no++;
    else check("send_timeout", int'(f), 1);
  endtask

  task automatic send_frame(input int w, input int h, input int base,
                            input bit neg, input bit gaps);
    int fr[$];
    int start = sample_no;
    for (int i = 0; i < w * h; i++) fr.push_back(neg ? -(i + 1) : base + i);
    model_frame(w, h, start, fr);
    for (int i = 0; i < w * h; i++) send_one(fr[i], gaps);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk_i); #1;
      n++;
    end
    repeat (4) begin @(posedge clk_i); #1; end
    check("drain_left", exp_q.size(), 0);
  endtask

  // Hold ready low until an output appears, verify it stays put, then toggle.
  task automatic stall_ctrl();
    int n = 0;
    logic signed [7:0] held;
    while (!vo && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check("stall_seen", int'(vo), 1);
    held = dout;
    repeat (10) begin
      @(negedge clk_i);
      check("stall_valid", int'(vo), 1);
      check("stall_data", int'(dout), int'(held));
      check("stall_ready", int'(ro), 0);
    end
    @(posedge clk_i); #1;
    repeat (60) begin
      ready_i = 1'($urandom_range(0, 1));
      @(posedge clk_i); #1;
    end
    ready_i = 1'b1;
  endtask

  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    data_i  = '0;
    sel     = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_valid", int'(vo), 0);
    check("rst_data", int'(dout), 0);
    check("rst_ready", int'(ro), 1);
    @(negedge clk_i) rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Ascending 4x4 frame, continuous flow, latency checked.
    lat_chk = 1;
    send_frame(4, 4, 0, 0, 0);
    drain();

    // Negative values: signed comparison.
    send_frame(4, 4, 0, 1, 0);
    drain();

    // 5x5: odd column/row dropped, back-to-back frames.
    sel = 1'b1;
    @(posedge clk_i); #1;
    send_frame(5, 5, 0, 0, 0);
    send_frame(5, 5, 100, 0, 0);
    drain();

    // 4x4 with input gaps, an initial 10-cycle stall and random backpressure.
    sel = 1'b0;
    lat_chk = 0;
    ready_i = 1'b0;
    @(posedge clk_i); #1;
    fork
      send_frame(4, 4, 0, 0, 1);
      stall_ctrl();
    join
    drain();

    // Asynchronous reset mid-frame with a pending output.
    ready_i = 1'b0;
    for (int i = 0; i < 6; i++) send_one(i, 0);
    @(negedge clk_i);
    check("pre_rst_valid", int'(vo), 1);
    check("pre_rst_data", int'(dout), 5);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_valid", int'(vo), 0);
    check("async_rst_data", int'(dout), 0);
    @(negedge clk_i);
    rst_i   = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    lat_chk = 1;
    send_frame(4, 4, 0, 0, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
